// File: rtl/ram_rd_streamer.sv
// Sequential RAM read engine: issues credit-limited reads and streams bytes out valid/ready.
// Optional RD_STREAMER_WRAP_EN: addresses wrap modulo 2**ADDR_W instead of rejecting overruns.
module ram_rd_streamer #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 12,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Start_i,
   input  logic [ADDR_W-1:0] StartAddr_i,
   input  logic [LEN_W-1:0]  Len_i,
   output logic              Busy_o,
   output logic              Done_o,
   output logic              Err_o,
   output logic [ADDR_W-1:0] RA_o,
   output logic              RClk_En_o,
   input  logic [DATA_W-1:0] RD_i,
   output logic [DATA_W-1:0] Data_o,
   output logic              Valid_o,
   input  logic              Ready_i,
   output logic              Last_o
);

   localparam int unsigned DEPTH   = RD_LAT + 2;
   localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W   = $clog2(DEPTH);
   localparam int unsigned MAX_LEN = 1 << ADDR_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_FIN
   } state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [LEN_W-1:0]   rem_q, rem_d;
   logic               err_q, err_d;
   logic [RD_LAT-1:0]  pipe_vld_q, pipe_vld_d;
   logic [RD_LAT-1:0]  pipe_last_q, pipe_last_d;
   logic [CNT_W-1:0]   infl_q, infl_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W:0]    mem_q [DEPTH];

   logic               req_ok;
   logic               len_zero;
   logic               issue;
   logic               push;
   logic               pop;
   logic               head_last;
   logic [CNT_W:0]     used;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
   endfunction

`ifdef RD_STREAMER_WRAP_EN
   always_comb begin
      req_ok = (32'(Len_i) <= MAX_LEN);
   end
`else
   logic [ADDR_W:0] end_addr;

   // Length is bounded first so the ADDR_W+1 bit end address cannot overflow.
   always_comb begin
      end_addr = {1'b0, StartAddr_i} + Len_i[ADDR_W:0];
      req_ok   = (32'(Len_i) <= MAX_LEN) && (32'(end_addr) <= MAX_LEN);
   end
`endif

   always_comb begin
      len_zero  = (Len_i == '0);
      used      = {1'b0, infl_q} + {1'b0, cnt_q};
      // Reads in flight plus buffered beats never exceed the FIFO depth.
      issue     = (state_q == ST_RUN) && (32'(used) < DEPTH);
      push      = pipe_vld_q[RD_LAT-1];
      pop       = (cnt_q != '0) && Ready_i;
      head_last = mem_q[rd_ptr_q][DATA_W];
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (Start_i) begin
               if (!req_ok) begin
                  err_d = 1'b1;
               end else if (len_zero) begin
                  state_d = ST_FIN;
               end else begin
                  state_d = ST_RUN;
                  addr_d  = StartAddr_i;
                  rem_d   = Len_i;
               end
            end
         end
         ST_RUN: begin
            if (issue) begin
               addr_d = addr_q + ADDR_W'(1);
               rem_d  = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (pop && head_last) begin
               state_d = ST_FIN;
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      pipe_vld_d  = RD_LAT'({pipe_vld_q, issue});
      pipe_last_d = RD_LAT'({pipe_last_q, issue && (rem_q == LEN_W'(1))});
      infl_d      = infl_q + CNT_W'(issue) - CNT_W'(push);
      cnt_d       = cnt_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d    = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d    = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         rem_q       <= '0;
         err_q       <= 1'b0;
         pipe_vld_q  <= '0;
         pipe_last_q <= '0;
         infl_q      <= '0;
         cnt_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         rem_q       <= rem_d;
         err_q       <= err_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_last_q <= pipe_last_d;
         infl_q      <= infl_d;
         cnt_q       <= cnt_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         if (push) begin
            mem_q[wr_ptr_q] <= {pipe_last_q[RD_LAT-1], RD_i};
         end
      end
   end

   assign Busy_o    = (state_q != ST_IDLE);
   assign Done_o    = (state_q == ST_FIN);
   assign Err_o     = err_q;
   assign RClk_En_o = issue;
   assign RA_o      = issue ? addr_q : '0;
   assign Valid_o   = (cnt_q != '0);
   assign Data_o    = Valid_o ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
   assign Last_o    = Valid_o && head_last;

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Randomized bench for ram_rd_streamer: expected bursts are computed from start/length
// against a RAM image; sampling happens on the falling edge, driving just after the rising edge.
module tb_ram_rd_streamer;

   localparam int unsigned NWORDS = 2048;
   localparam int          DEPTH  = 3;
`ifdef RD_STREAMER_WRAP_EN
   localparam bit WRAP = 1'b1;
`else
   localparam bit WRAP = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst_n, Start_i, Busy_o, Done_o, Err_o, RClk_En_o, Valid_o, Ready_i, Last_o;
   logic [10:0] StartAddr_i, RA_o;
   logic [11:0] Len_i;
   logic [7:0]  RD_i = '0;
   logic [7:0]  Data_o;

   always #5 Clk = ~Clk;

   ram_rd_streamer #(.ADDR_W(11), .DATA_W(8), .LEN_W(12), .RD_LAT(1)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start_i(Start_i), .StartAddr_i(StartAddr_i), .Len_i(Len_i),
      .Busy_o(Busy_o), .Done_o(Done_o), .Err_o(Err_o), .RA_o(RA_o), .RClk_En_o(RClk_En_o),
      .RD_i(RD_i), .Data_o(Data_o), .Valid_o(Valid_o), .Ready_i(Ready_i), .Last_o(Last_o)
   );

   // RAM image with one clock of read latency
   logic [7:0]  ram [NWORDS];
   logic        ram_en_s = 1'b0;
   logic [10:0] ram_a_s  = '0;
   always @(negedge Clk) begin
      ram_en_s <= RClk_En_o;
      ram_a_s  <= RA_o;
   end
   always @(posedge Clk) if (ram_en_s) RD_i <= ram[ram_a_s];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   logic [10:0] exp_ra[$];
   logic [8:0]  exp_beat[$];
   int cyc = 0, start_cyc = -10;
   int issued = 0, xferred = 0, done_cnt = 0, err_cnt = 0, burst_xfer = 0;
   int first_issue_cyc, first_valid_cyc, first_xfer_cyc, last_xfer_cyc, done_cyc, err_cyc;
   bit busy_s, prev_stall = 1'b0;
   logic [8:0] prev_beat;
   int rdy_mode = 0;

   task automatic monitor();
      if (cyc == start_cyc) busy_s = Busy_o;
      if (prev_stall) chk("hold", 32'({Valid_o, Last_o, Data_o}), 32'({1'b1, prev_beat}));
      if (RClk_En_o) begin
         chk("credit", 32'((issued - xferred) < DEPTH), 32'd1);
         if (first_issue_cyc < 0) first_issue_cyc = cyc;
         if (exp_ra.size() == 0) chk("ra_extra", 32'(RA_o), 32'hFFFF_FFFF);
         else chk("ra", 32'(RA_o), 32'(exp_ra.pop_front()));
         issued++;
      end
      if (Valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (Valid_o && Ready_i) begin
         if (exp_beat.size() == 0) chk("beat_extra", 32'({Last_o, Data_o}), 32'hFFFF_FFFF);
         else chk("beat", 32'({Last_o, Data_o}), 32'(exp_beat.pop_front()));
         if (burst_xfer == 0) first_xfer_cyc = cyc;
         last_xfer_cyc = cyc;
         burst_xfer++;
         xferred++;
      end
      prev_stall = Valid_o && !Ready_i;
      prev_beat  = {Last_o, Data_o};
      if (Done_o) begin done_cnt++; done_cyc = cyc; end
      if (Err_o)  begin err_cnt++;  err_cyc  = cyc; end
   endtask

   task automatic step();
      @(negedge Clk);
      if (Rst_n) monitor();
      @(posedge Clk);
      cyc++;
      #1;
      case (rdy_mode)
         0:       Ready_i = 1'b1;
         1:       Ready_i = ~Ready_i;
         default: Ready_i = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_burst(input logic [10:0] a, input int len, input int mode, input bit spur);
      bit legal;
      int d0, e0, budget;
      legal = (len <= int'(NWORDS)) && (WRAP || (int'(a) + len <= int'(NWORDS)));
      rdy_mode = mode;
      if (legal) begin
         for (int i = 0; i < len; i++) begin
            exp_ra.push_back(11'((int'(a) + i) % NWORDS));
            exp_beat.push_back({i == len - 1, ram[(int'(a) + i) % NWORDS]});
         end
      end
      d0 = done_cnt; e0 = err_cnt; burst_xfer = 0;
      first_issue_cyc = -1; first_valid_cyc = -1; done_cyc = -1; err_cyc = -1;
      StartAddr_i = a; Len_i = 12'(len); Start_i = 1'b1;
      start_cyc = cyc + 1;
      step();
      Start_i = 1'b0;
      budget = 8 * len + 40;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt != d0 || err_cnt != e0) break;
         if (spur && i == 3) begin
            Start_i = 1'b1; StartAddr_i = 11'($urandom); Len_i = 12'($urandom_range(1, 50));
         end else begin
            Start_i = 1'b0;
         end
         step();
      end
      Start_i = 1'b0;
      repeat (4) step();
      chk("end_seen", 32'(done_cnt != d0 || err_cnt != e0), 32'd1);
      chk("done_cnt", 32'(done_cnt - d0), 32'(legal));
      chk("err_cnt", 32'(err_cnt - e0), 32'(!legal));
      chk("busy_after_start", 32'(busy_s), 32'(legal));
      chk("ra_left", 32'(exp_ra.size()), 32'd0);
      chk("beats_left", 32'(exp_beat.size()), 32'd0);
      if (!legal) begin
         chk("err_lat", 32'(err_cyc - start_cyc), 32'd0);
         chk("err_no_issue", 32'(first_issue_cyc), 32'hFFFF_FFFF);
      end else if (len == 0) begin
         chk("zero_done_lat", 32'(done_cyc - start_cyc), 32'd0);
         chk("zero_no_issue", 32'(first_issue_cyc), 32'hFFFF_FFFF);
         chk("zero_no_valid", 32'(first_valid_cyc), 32'hFFFF_FFFF);
      end else begin
         chk("issue_lat", 32'(first_issue_cyc - start_cyc), 32'd0);
         chk("valid_lat", 32'(first_valid_cyc - start_cyc), 32'd2);
         chk("done_lat", 32'(done_cyc - last_xfer_cyc), 32'd1);
         if (mode == 0) chk("b2b", 32'(last_xfer_cyc - first_xfer_cyc), 32'(len - 1));
      end
   endtask

   initial begin
      int d_before;
      logic [10:0] ra;
      for (int i = 0; i < int'(NWORDS); i++) ram[i] = 8'($urandom);
      Rst_n = 1'b0; Start_i = 1'b0; Ready_i = 1'b1; StartAddr_i = '0; Len_i = '0;
      repeat (3) step();
      chk("reset_outs", 32'({Busy_o, Done_o, Err_o, RClk_En_o, Valid_o, Last_o, RA_o, Data_o}), 32'd0);
      Rst_n = 1'b1;
      step();
      chk("idle_outs", 32'({Busy_o, Done_o, Err_o, RClk_En_o, Valid_o, Last_o, RA_o, Data_o}), 32'd0);

      do_burst(11'h010, 4, 0, 1'b0);
      ra = 11'($urandom_range(0, 2000));
      do_burst(ra, 16, 1, 1'b0);
      do_burst(11'h123, 0, 0, 1'b0);
      do_burst(11'h7FE, 4, 0, 1'b0);

      // Reset in the middle of an 8-beat burst
      rdy_mode = 0;
      for (int i = 0; i < 8; i++) begin
         exp_ra.push_back(11'(11'h200 + i));
         exp_beat.push_back({i == 7, ram[11'h200 + i]});
      end
      burst_xfer = 0;
      StartAddr_i = 11'h200; Len_i = 12'd8; Start_i = 1'b1;
      step();
      Start_i = 1'b0;
      for (int i = 0; i < 40 && burst_xfer < 3; i++) step();
      chk("pre_reset_beats", 32'(burst_xfer), 32'd3);
      #2 Rst_n = 1'b0;
      #1 chk("rst_outs", 32'({Busy_o, Done_o, Err_o, RClk_En_o, Valid_o, Last_o, RA_o, Data_o}), 32'd0);
      exp_ra.delete(); exp_beat.delete();
      issued = 0; xferred = 0; prev_stall = 1'b0;
      d_before = done_cnt;
      repeat (3) step();
      Rst_n = 1'b1;
      repeat (3) step();
      chk("rst_no_done", 32'(done_cnt - d_before), 32'd0);
      do_burst(11'h100, 2, 0, 1'b0);

      do_burst(11'h040, 20, 2, 1'b1);
      do_burst(11'h000, 2048, 2, 1'b0);
      do_burst(11'h400, 2049, 0, 1'b0);
      do_burst(11'h700, 256, 0, 1'b0);
      do_burst(11'h701, 256, 1, 1'b0);

      for (int n = 0; n < 24; n++) begin
         int len, mode;
         bit spur;
         len  = $urandom_range(0, 40);
         mode = $urandom_range(0, 2);
         spur = (len >= 8) && ($urandom_range(0, 1) == 1);
         do_burst(11'($urandom), len, mode, spur);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
